// File: rtl/sdram_cmd_monitor.sv
// Passive SDRAM command monitor: decode, bank tracking, read-valid window, counters, error flags.
// Optional tRCD checking is built when SDRAM_MON_TRCD_CHECK_EN is defined.
module sdram_cmd_monitor #(
  parameter int BL    = 4,
  parameter int CNT_W = 16,
  parameter int TRCD  = 2
) (
  input  logic             sdram_clk,
  input  logic             sdram_resetn,
  input  logic             sdram_en,
  input  logic             sdram_ras_n,
  input  logic             sdram_cas_n,
  input  logic             sdram_we_n,
  input  logic [1:0]       sdram_ba,
  input  logic             sdram_a10,
  input  logic [1:0]       sdram_cas,
  input  logic             stat_clr,
  output logic             cmd_valid,
  output logic [2:0]       cmd_code,
  output logic             rd_dv,
  output logic [3:0]       bank_open,
  output logic [CNT_W-1:0] cnt_act,
  output logic [CNT_W-1:0] cnt_rd,
  output logic [CNT_W-1:0] cnt_wr,
  output logic [CNT_W-1:0] cnt_pre,
  output logic [CNT_W-1:0] cnt_ref,
  output logic [3:0]       err_flags,
  output logic             err_pulse
);

  localparam int BW = (BL > 1) ? $clog2(BL) : 1;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0, CMD_ACT = 3'd1, CMD_RD  = 3'd2, CMD_WR  = 3'd3,
    CMD_PRE = 3'd4, CMD_REF = 3'd5, CMD_MRS = 3'd6, CMD_BST = 3'd7
  } cmd_t;

  cmd_t          cmd;
  logic          is_act, is_rd, is_wr, is_pre, is_ref, is_bst;
  logic          bank_hit, start_cl2, start_cl3, kill, trcd_err;
  logic [3:0]    err_ev, bank_next;
  logic [2:0]    dl;
  logic [BW-1:0] beat_cnt;

  always_comb begin
    cmd = CMD_NOP;
    if (sdram_en) begin
      case ({sdram_ras_n, sdram_cas_n, sdram_we_n})
        3'b011:  cmd = CMD_ACT;
        3'b101:  cmd = CMD_RD;
        3'b100:  cmd = CMD_WR;
        3'b010:  cmd = CMD_PRE;
        3'b001:  cmd = CMD_REF;
        3'b000:  cmd = CMD_MRS;
        3'b110:  cmd = CMD_BST;
        default: cmd = CMD_NOP;
      endcase
    end
  end

  assign is_act   = (cmd == CMD_ACT);
  assign is_rd    = (cmd == CMD_RD);
  assign is_wr    = (cmd == CMD_WR);
  assign is_pre   = (cmd == CMD_PRE);
  assign is_ref   = (cmd == CMD_REF);
  assign is_bst   = (cmd == CMD_BST);
  assign bank_hit = bank_open[sdram_ba];

  // A read with an illegal CAS latency matches neither tap, so it never opens a window.
  assign start_cl2 = is_rd && (sdram_cas == 2'd2);
  assign start_cl3 = is_rd && (sdram_cas == 2'd3);
  assign kill      = is_bst || is_wr;

  assign err_ev[0] = (is_rd || is_wr) && !bank_hit;
  assign err_ev[1] = is_act && bank_hit;
  assign err_ev[2] = is_rd && !(sdram_cas == 2'd2 || sdram_cas == 2'd3);
  assign err_ev[3] = trcd_err;

  always_comb begin
    bank_next = bank_open;
    if (is_act) begin
      bank_next[sdram_ba] = 1'b1;
    end else if (is_pre) begin
      if (sdram_a10) bank_next = 4'b0000;
      else           bank_next[sdram_ba] = 1'b0;
    end else if ((is_rd || is_wr) && sdram_a10) begin
      bank_next[sdram_ba] = 1'b0;
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic hit);
    return (hit && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

`ifdef SDRAM_MON_TRCD_CHECK_EN
  localparam int TW = (TRCD > 1) ? $clog2(TRCD) : 1;
  logic [TW-1:0] trcd_cnt [4];

  assign trcd_err = (is_rd || is_wr) && (trcd_cnt[sdram_ba] != '0);

  always_ff @(posedge sdram_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (!sdram_resetn)
        trcd_cnt[b] <= '0;
      else if (is_act && (sdram_ba == 2'(b)))
        trcd_cnt[b] <= TW'(TRCD - 1);
      else if (trcd_cnt[b] != '0)
        trcd_cnt[b] <= trcd_cnt[b] - TW'(1);
    end
  end
`else
  assign trcd_err = 1'b0 && (TRCD > 0);
`endif

  always_ff @(posedge sdram_clk) begin
    if (!sdram_resetn) begin
      cmd_valid <= 1'b0;
      cmd_code  <= 3'd0;
      rd_dv     <= 1'b0;
      bank_open <= 4'b0000;
      cnt_act   <= '0;
      cnt_rd    <= '0;
      cnt_wr    <= '0;
      cnt_pre   <= '0;
      cnt_ref   <= '0;
      err_flags <= 4'b0000;
      err_pulse <= 1'b0;
      dl        <= 3'b000;
      beat_cnt  <= '0;
    end else begin
      cmd_valid <= (cmd != CMD_NOP);
      cmd_code  <= cmd;
      bank_open <= bank_next;
      err_pulse <= |err_ev;
      if (stat_clr) begin
        cnt_act   <= '0;
        cnt_rd    <= '0;
        cnt_wr    <= '0;
        cnt_pre   <= '0;
        cnt_ref   <= '0;
        err_flags <= 4'b0000;
      end else begin
        cnt_act   <= sat_inc(cnt_act, is_act);
        cnt_rd    <= sat_inc(cnt_rd, is_rd);
        cnt_wr    <= sat_inc(cnt_wr, is_wr);
        cnt_pre   <= sat_inc(cnt_pre, is_pre);
        cnt_ref   <= sat_inc(cnt_ref, is_ref);
        err_flags <= err_flags | err_ev;
      end
      // rd_dv reflects the state before this edge, so a kill drops it one cycle later.
      rd_dv <= dl[0] || (beat_cnt != '0);
      if (kill) begin
        dl       <= 3'b000;
        beat_cnt <= '0;
      end else begin
        dl <= {start_cl3, dl[2] | start_cl2, dl[1]};
        if (dl[0])
          beat_cnt <= BW'(BL - 1);
        else if (beat_cnt != '0)
          beat_cnt <= beat_cnt - BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sdram_cmd_monitor.sv
// Directed self-checking bench for sdram_cmd_monitor (BL=4, CNT_W=8, TRCD=3).
module tb_sdram_cmd_monitor;

  localparam logic [2:0] C_NOP = 3'd0, C_ACT = 3'd1, C_RD = 3'd2, C_WR = 3'd3,
                         C_PRE = 3'd4, C_REF = 3'd5, C_BST = 3'd7;

  logic       sdram_clk = 1'b0;
  logic       sdram_resetn, sdram_en, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0] sdram_ba, sdram_cas;
  logic       sdram_a10, stat_clr;
  logic       cmd_valid, rd_dv, err_pulse;
  logic [2:0] cmd_code;
  logic [3:0] bank_open, err_flags;
  logic [7:0] cnt_act, cnt_rd, cnt_wr, cnt_pre, cnt_ref;

  int n_checks = 0;
  int n_fail   = 0;

  sdram_cmd_monitor #(.BL(4), .CNT_W(8), .TRCD(3)) dut (
    .sdram_clk(sdram_clk), .sdram_resetn(sdram_resetn), .sdram_en(sdram_en),
    .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_ba(sdram_ba), .sdram_a10(sdram_a10), .sdram_cas(sdram_cas),
    .stat_clr(stat_clr), .cmd_valid(cmd_valid), .cmd_code(cmd_code), .rd_dv(rd_dv),
    .bank_open(bank_open), .cnt_act(cnt_act), .cnt_rd(cnt_rd), .cnt_wr(cnt_wr),
    .cnt_pre(cnt_pre), .cnt_ref(cnt_ref), .err_flags(err_flags), .err_pulse(err_pulse)
  );

  always #5 sdram_clk = ~sdram_clk;

  // Drive one command at the falling edge, then return just after the rising edge that samples it.
  // NOP is driven as a deselect carrying a READ pin pattern.
  task automatic applyStimulus(input logic [2:0] code, input logic [1:0] ba, input logic a10);
    @(negedge sdram_clk);
    sdram_en  = 1'b1;
    sdram_ba  = ba;
    sdram_a10 = a10;
    case (code)
      C_ACT:   {sdram_ras_n, sdram_cas_n, sdram_we_n} = 3'b011;
      C_RD:    {sdram_ras_n, sdram_cas_n, sdram_we_n} = 3'b101;
      C_WR:    {sdram_ras_n, sdram_cas_n, sdram_we_n} = 3'b100;
      C_PRE:   {sdram_ras_n, sdram_cas_n, sdram_we_n} = 3'b010;
      C_REF:   {sdram_ras_n, sdram_cas_n, sdram_we_n} = 3'b001;
      C_BST:   {sdram_ras_n, sdram_cas_n, sdram_we_n} = 3'b110;
      default: begin
        sdram_en = 1'b0;
        {sdram_ras_n, sdram_cas_n, sdram_we_n} = 3'b101;
      end
    endcase
    @(posedge sdram_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic any_dv;
    sdram_resetn = 1'b0;
    sdram_en = 1'b0;
    {sdram_ras_n, sdram_cas_n, sdram_we_n} = 3'b111;
    sdram_ba = 2'd0;
    sdram_a10 = 1'b0;
    sdram_cas = 2'd2;
    stat_clr = 1'b0;

    // Reset, then one idle cycle.
    for (int i = 0; i < 3; i++) applyStimulus(C_NOP, 2'd0, 1'b0);
    sdram_resetn = 1'b1;
    applyStimulus(C_NOP, 2'd0, 1'b0);
    checkOutput("rst_cmd_valid", 32'(cmd_valid), 0);
    checkOutput("rst_cmd_code", 32'(cmd_code), 0);
    checkOutput("rst_rd_dv", 32'(rd_dv), 0);
    checkOutput("rst_bank_open", 32'(bank_open), 0);
    checkOutput("rst_counters", {cnt_act, cnt_rd, cnt_wr, cnt_pre}, 0);
    checkOutput("rst_err", {27'd0, err_flags, err_pulse}, 0);

    // ACT then CL=2 read on bank 1.
    applyStimulus(C_ACT, 2'd1, 1'b0);
    checkOutput("act_valid_code", {28'd0, cmd_valid, cmd_code}, 'h9);
    checkOutput("act_bank_open", 32'(bank_open), 'h2);
    checkOutput("act_cnt_act", 32'(cnt_act), 1);
    applyStimulus(C_RD, 2'd1, 1'b0);
    checkOutput("rd_code", 32'(cmd_code), 2);
    checkOutput("rd_cnt_rd", 32'(cnt_rd), 1);
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(C_NOP, 2'd0, 1'b0);
      checkOutput($sformatf("cl2_rd_dv_k%0d", k), 32'(rd_dv), 32'((k >= 2) && (k <= 5)));
    end
    checkOutput("cl2_idle_valid", 32'(cmd_valid), 0);

    // Read to a closed bank, then statistics clear.
    applyStimulus(C_RD, 2'd2, 1'b0);
    checkOutput("closed_err_flags", 32'(err_flags), 'h1);
    checkOutput("closed_err_pulse", 32'(err_pulse), 1);
    applyStimulus(C_NOP, 2'd0, 1'b0);
    checkOutput("closed_pulse_drop", 32'(err_pulse), 0);
    checkOutput("closed_flag_sticky", 32'(err_flags), 'h1);
    stat_clr = 1'b1;
    applyStimulus(C_NOP, 2'd0, 1'b0);
    stat_clr = 1'b0;
    checkOutput("clr_err_flags", 32'(err_flags), 0);
    checkOutput("clr_cnt_rd", 32'(cnt_rd), 0);
    checkOutput("clr_keeps_bank", 32'(bank_open), 'h2);
    for (int i = 0; i < 6; i++) applyStimulus(C_NOP, 2'd0, 1'b0);

    // Single-bank and all-bank precharge, double ACT, auto-precharge.
    applyStimulus(C_PRE, 2'd1, 1'b0);
    checkOutput("pre1_bank_open", 32'(bank_open), 0);
    stat_clr = 1'b1;
    applyStimulus(C_NOP, 2'd0, 1'b0);
    stat_clr = 1'b0;
    applyStimulus(C_ACT, 2'd0, 1'b0);
    applyStimulus(C_ACT, 2'd1, 1'b0);
    applyStimulus(C_ACT, 2'd2, 1'b0);
    checkOutput("act3_bank_open", 32'(bank_open), 'h7);
    checkOutput("act3_cnt_act", 32'(cnt_act), 3);
    applyStimulus(C_PRE, 2'd0, 1'b1);
    checkOutput("preall_bank_open", 32'(bank_open), 0);
    checkOutput("preall_cnt_pre", 32'(cnt_pre), 1);
    applyStimulus(C_ACT, 2'd0, 1'b0);
    checkOutput("act0_no_err", 32'(err_flags), 0);
    applyStimulus(C_ACT, 2'd0, 1'b0);
    checkOutput("react_err_flags", 32'(err_flags), 'h2);
    checkOutput("react_err_pulse", 32'(err_pulse), 1);
    checkOutput("react_bank_open", 32'(bank_open), 'h1);
    applyStimulus(C_RD, 2'd0, 1'b1);
    checkOutput("autopre_bank_open", 32'(bank_open), 0);
    checkOutput("autopre_err_flags", 32'(err_flags), 'h2);
    for (int i = 0; i < 6; i++) applyStimulus(C_NOP, 2'd0, 1'b0);

    // Illegal CAS latency: error, no read window.
    stat_clr = 1'b1;
    applyStimulus(C_NOP, 2'd0, 1'b0);
    stat_clr = 1'b0;
    applyStimulus(C_ACT, 2'd3, 1'b0);
    sdram_cas = 2'd1;
    applyStimulus(C_RD, 2'd3, 1'b0);
    checkOutput("badcas_err_flags", 32'(err_flags), 'h4);
    checkOutput("badcas_err_pulse", 32'(err_pulse), 1);
    any_dv = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(C_NOP, 2'd0, 1'b0);
      any_dv = any_dv | rd_dv;
    end
    checkOutput("badcas_no_window", 32'(any_dv), 0);

    // CL=3 read cut short by BST on the fourth edge after issue.
    sdram_cas = 2'd3;
    applyStimulus(C_RD, 2'd3, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      applyStimulus((k == 4) ? C_BST : C_NOP, 2'd3, 1'b0);
      checkOutput($sformatf("bst_rd_dv_k%0d", k), 32'(rd_dv), 32'((k == 3) || (k == 4)));
    end

    // Back-to-back CL=2 reads every BL cycles give one continuous window.
    sdram_cas = 2'd2;
    applyStimulus(C_RD, 2'd3, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      applyStimulus((k == 4) ? C_RD : C_NOP, 2'd3, 1'b0);
      checkOutput($sformatf("b2b_rd_dv_k%0d", k), 32'(rd_dv), 32'((k >= 2) && (k <= 9)));
    end

    // WRITE truncates an in-flight read burst.
    applyStimulus(C_RD, 2'd3, 1'b0);
    applyStimulus(C_NOP, 2'd0, 1'b0);
    applyStimulus(C_NOP, 2'd0, 1'b0);
    applyStimulus(C_WR, 2'd3, 1'b0);
    checkOutput("wr_trunc_last_beat", 32'(rd_dv), 1);
    applyStimulus(C_NOP, 2'd0, 1'b0);
    checkOutput("wr_trunc_rd_dv", 32'(rd_dv), 0);
    checkOutput("wr_cnt_wr", 32'(cnt_wr), 1);

    // Saturating refresh counter.
    for (int i = 0; i < 255; i++) applyStimulus(C_REF, 2'd0, 1'b0);
    checkOutput("ref_reach_max", 32'(cnt_ref), 'hFF);
    applyStimulus(C_REF, 2'd0, 1'b0);
    applyStimulus(C_REF, 2'd0, 1'b0);
    checkOutput("ref_saturate", 32'(cnt_ref), 'hFF);

    // Reset in the middle of a burst.
    applyStimulus(C_RD, 2'd3, 1'b0);
    applyStimulus(C_NOP, 2'd0, 1'b0);
    applyStimulus(C_NOP, 2'd0, 1'b0);
    checkOutput("pre_reset_rd_dv", 32'(rd_dv), 1);
    sdram_resetn = 1'b0;
    applyStimulus(C_NOP, 2'd0, 1'b0);
    sdram_resetn = 1'b1;
    checkOutput("midburst_rst_rd_dv", 32'(rd_dv), 0);
    checkOutput("midburst_rst_bank", 32'(bank_open), 0);
    checkOutput("midburst_rst_cnt_ref", 32'(cnt_ref), 0);

    // tRCD: read one edge after ACT, then three edges after ACT.
    applyStimulus(C_ACT, 2'd0, 1'b0);
    applyStimulus(C_RD, 2'd0, 1'b0);
`ifdef SDRAM_MON_TRCD_CHECK_EN
    checkOutput("trcd_early_err", {27'd0, err_flags, err_pulse}, 'h11);
`else
    checkOutput("trcd_early_err", {27'd0, err_flags, err_pulse}, 'h0);
`endif
    stat_clr = 1'b1;
    applyStimulus(C_NOP, 2'd0, 1'b0);
    stat_clr = 1'b0;
    applyStimulus(C_RD, 2'd0, 1'b0);
    checkOutput("trcd_met_err", {27'd0, err_flags, err_pulse}, 'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
